dp_control_unit: RTL and testbench
==================================

Name: dp_control_unit

Overview:
- Control sequencer that sits directly upstream of the RegisterFile / BarrelShifter / ARM_ALU datapath.
- Fetches a 32-bit instruction from memory using an MOV/MFC handshake and holds it in an internal instruction register.
- Evaluates the ARM condition field against the current flags.
- Drives the datapath control signals (RSLCT, OP, S, ALU_OUT, LOAD, LOADPC, IR_CU) that benches currently drive by hand.
- Handles data-processing instructions only; all other classes are flagged undefined and skipped.

Parameters:
CNT_W, 16, width of the retired-instruction counter
FETCH_TIMEOUT, 255, maximum number of FETCH cycles without MFC before TIMEOUT is raised

Ports:
Clk  input  1  system clock; all state changes on the rising edge
RESET  input  1  synchronous, active-high reset
MEM_DATA  input  32  instruction word from memory, valid when MFC=1
MFC  input  1  memory function complete
FLAGS  input  4  {N,Z,C,V} from the ALU status register (FLAGS[1]=C)
IR  output  32  latched instruction; also feeds the BarrelShifter IR input
MOV  output  1  memory read request
RSLCT  output  20  register selects: [19:16]=Rn, [15:12]=Rd, [11:8]=Rs, [7:4]=Rm, [3:0]=write destination
OP  output  5  ALU opcode
S  output  1  ALU flag-update enable
ALU_OUT  output  1  ALU output-bus enable
LOAD  output  1  register file write enable
LOADPC  output  1  PC load enable
PC_INC  output  1  selects PC+4 path into Pcin
IR_CU  output  1  1 = selects taken from IR, 0 = CU forces R15
UNDEF  output  1  one-cycle pulse on a non-data-processing instruction
TIMEOUT  output  1  sticky; set on fetch timeout
RETIRED  output  CNT_W  count of executed (condition-passed) instructions

Behaviour:
- Reset: synchronous. Any rising edge with RESET=1 moves the FSM to FETCH and sets every output to its reset value:
  - IR=0, MOV=0, RSLCT=0, OP=17, S=0, ALU_OUT=0
  - LOAD=0, LOADPC=0, PC_INC=0, IR_CU=0
  - UNDEF=0, TIMEOUT=0, RETIRED=0, internal timeout counter=0
- Reset mid-fetch or mid-execute aborts the instruction with no write.
- States: FETCH -> PC_UPD -> DECODE -> EXECUTE -> FETCH. DECODE returns straight to FETCH when the condition fails or the instruction is undefined.
- FETCH:
  - MOV=1, IR_CU=0, RSLCT[19:16]=4'hF.
  - On an edge with MFC=1: IR<=MEM_DATA, MOV deasserts next cycle, go to PC_UPD.
  - Each cycle without MFC increments the timeout counter.
  - When the counter reaches FETCH_TIMEOUT: TIMEOUT<=1 and the FSM stays in FETCH, retrying MOV. Only RESET clears TIMEOUT.
- PC_UPD: one cycle with LOADPC=1, PC_INC=1, IR_CU=0; all else idle.
- DECODE (one cycle):
  - RSLCT={IR[19:16],IR[15:12],IR[11:8],IR[3:0],IR[15:12]}, IR_CU=1.
  - Condition IR[31:28] is evaluated with the standard ARM table (EQ..AL). 4'hF = never.
  - If IR[27:26]!=2'b00: UNDEF=1 for this cycle, go to FETCH.
  - Else if the condition fails: go to FETCH.
  - Else: go to EXECUTE.
- EXECUTE (one cycle):
  - OP={1'b0,IR[24:21]}, S=IR[20], ALU_OUT=1, IR_CU=1, RSLCT held.
  - LOAD=1 except for opcodes 8..11 (TST/TEQ/CMP/CMN), where LOAD=0.
  - RETIRED increments by 1 and wraps from all-ones to 0.
- Outside EXECUTE: OP=17 (ALU idle), S=0, ALU_OUT=0, LOAD=0.
- FLAGS are sampled only in DECODE. Flag changes in other states have no effect on the current instruction.
- Minimum latency is 4 cycles per executed instruction (MFC already high on the first FETCH edge), 3 cycles for skipped or undefined instructions.
- All outputs are registered. No output may depend combinationally on MFC or FLAGS.

Test Plan:
- RESET=1 for 2 cycles, then 0, MFC tied 1, MEM_DATA=0xE0812003:
  - IR=0xE0812003, PC_UPD shows LOADPC=1/PC_INC=1.
  - EXECUTE shows OP=4, S=0, RSLCT=0x12032, LOAD=1, ALU_OUT=1.
  - RETIRED=1 after 4 cycles.
- MEM_DATA=0xE1510002 (CMP R1,R2) -> EXECUTE with OP=10, S=1, LOAD=0, RETIRED increments.
- MEM_DATA=0x00812003 (ADDEQ) with FLAGS=4'b0000 -> no EXECUTE, LOAD never 1, RETIRED unchanged, next FETCH 3 cycles after the first. Repeat with FLAGS=4'b0100 -> executes.
- MEM_DATA=0xE5912000 (LDR) -> UNDEF=1 for exactly one cycle in DECODE, no LOAD, RETIRED unchanged.
- MFC held 0 with FETCH_TIMEOUT=4 -> MOV stays 1, TIMEOUT=1 after 4 cycles. Then MFC=1 -> fetch completes, TIMEOUT stays 1 until RESET.
- RESET asserted during EXECUTE -> next edge LOAD=0, OP=17, IR=0, RETIRED=0, FSM in FETCH.

Source files
------------

// File: rtl/dp_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : dp_control_unit
// Brief    : Fetch/decode/execute sequencer for the RegisterFile, BarrelShifter
//            and ARM_ALU datapath; data-processing instructions only.
// Revision : 1.0 - initial release
// ============================================================================
module dp_control_unit #(
    parameter int CNT_W         = 16,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic             Clk,
    input  logic             RESET,
    input  logic [31:0]      MEM_DATA,
    input  logic             MFC,
    input  logic [3:0]       FLAGS,
    output logic [31:0]      IR,
    output logic             MOV,
    output logic [19:0]      RSLCT,
    output logic [4:0]       OP,
    output logic             S,
    output logic             ALU_OUT,
    output logic             LOAD,
    output logic             LOADPC,
    output logic             PC_INC,
    output logic             IR_CU,
    output logic             UNDEF,
    output logic             TIMEOUT,
    output logic [CNT_W-1:0] RETIRED
);

    localparam int              c_TO_W    = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_MAX  = c_TO_W'(FETCH_TIMEOUT);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(FETCH_TIMEOUT - 1);

    localparam logic [1:0]  c_FETCH    = 2'd0;
    localparam logic [1:0]  c_PC_UPD   = 2'd1;
    localparam logic [1:0]  c_DECODE   = 2'd2;
    localparam logic [1:0]  c_EXECUTE  = 2'd3;

    localparam logic [4:0]  c_OP_IDLE  = 5'd17;
    localparam logic [19:0] c_RSLCT_PC = 20'hF0000;

    logic [1:0]        r_state;
    logic [31:0]       r_ir;
    logic              r_mov;
    logic [19:0]       r_rslct;
    logic [4:0]        r_op;
    logic              r_s;
    logic              r_alu_out;
    logic              r_load;
    logic              r_loadpc;
    logic              r_pc_inc;
    logic              r_ir_cu;
    logic              r_undef;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_retired;
    logic [c_TO_W-1:0] r_to_cnt;

    logic w_n, w_z, w_c, w_v;
    logic w_cond_pass;
    logic w_is_dp;
    logic w_is_test;

    assign w_n       = FLAGS[3];
    assign w_z       = FLAGS[2];
    assign w_c       = FLAGS[1];
    assign w_v       = FLAGS[0];
    assign w_is_dp   = (r_ir[27:26] == 2'b00);
    // TST/TEQ/CMP/CMN occupy opcodes 8..11 and only update flags
    assign w_is_test = (r_ir[24:23] == 2'b10);

    always_comb begin
        w_cond_pass = 1'b0;
        case (r_ir[31:28])
            4'h0:    w_cond_pass = w_z;
            4'h1:    w_cond_pass = ~w_z;
            4'h2:    w_cond_pass = w_c;
            4'h3:    w_cond_pass = ~w_c;
            4'h4:    w_cond_pass = w_n;
            4'h5:    w_cond_pass = ~w_n;
            4'h6:    w_cond_pass = w_v;
            4'h7:    w_cond_pass = ~w_v;
            4'h8:    w_cond_pass = w_c & ~w_z;
            4'h9:    w_cond_pass = ~w_c | w_z;
            4'hA:    w_cond_pass = (w_n == w_v);
            4'hB:    w_cond_pass = (w_n != w_v);
            4'hC:    w_cond_pass = ~w_z & (w_n == w_v);
            4'hD:    w_cond_pass = w_z | (w_n != w_v);
            4'hE:    w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (RESET) begin
            r_state   <= c_FETCH;
            r_ir      <= '0;
            r_mov     <= 1'b0;
            r_rslct   <= '0;
            r_op      <= c_OP_IDLE;
            r_s       <= 1'b0;
            r_alu_out <= 1'b0;
            r_load    <= 1'b0;
            r_loadpc  <= 1'b0;
            r_pc_inc  <= 1'b0;
            r_ir_cu   <= 1'b0;
            r_undef   <= 1'b0;
            r_timeout <= 1'b0;
            r_retired <= '0;
            r_to_cnt  <= '0;
        end else begin
            // Single-cycle controls fall back to idle unless the next state asks for them
            r_op      <= c_OP_IDLE;
            r_s       <= 1'b0;
            r_alu_out <= 1'b0;
            r_load    <= 1'b0;
            r_loadpc  <= 1'b0;
            r_pc_inc  <= 1'b0;
            r_undef   <= 1'b0;
            case (r_state)
                c_FETCH: begin
                    r_ir_cu <= 1'b0;
                    r_rslct <= c_RSLCT_PC;
                    if (MFC) begin
                        r_ir     <= MEM_DATA;
                        r_mov    <= 1'b0;
                        r_to_cnt <= '0;
                        r_loadpc <= 1'b1;
                        r_pc_inc <= 1'b1;
                        r_state  <= c_PC_UPD;
                    end else begin
                        r_mov <= 1'b1;
                        if (r_to_cnt != c_TO_MAX) begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                        if (r_to_cnt == c_TO_LAST) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                c_PC_UPD: begin
                    r_rslct <= {r_ir[19:16], r_ir[15:12], r_ir[11:8], r_ir[3:0], r_ir[15:12]};
                    r_ir_cu <= 1'b1;
                    r_undef <= ~w_is_dp;
                    r_state <= c_DECODE;
                end
                c_DECODE: begin
                    if (!w_is_dp || !w_cond_pass) begin
                        r_mov   <= 1'b1;
                        r_ir_cu <= 1'b0;
                        r_rslct <= c_RSLCT_PC;
                        r_state <= c_FETCH;
                    end else begin
                        r_op      <= {1'b0, r_ir[24:21]};
                        r_s       <= r_ir[20];
                        r_alu_out <= 1'b1;
                        r_load    <= ~w_is_test;
                        r_retired <= r_retired + 1'b1;
                        r_state   <= c_EXECUTE;
                    end
                end
                default: begin
                    r_mov   <= 1'b1;
                    r_ir_cu <= 1'b0;
                    r_rslct <= c_RSLCT_PC;
                    r_state <= c_FETCH;
                end
            endcase
        end
    end

    assign IR      = r_ir;
    assign MOV     = r_mov;
    assign RSLCT   = r_rslct;
    assign OP      = r_op;
    assign S       = r_s;
    assign ALU_OUT = r_alu_out;
    assign LOAD    = r_load;
    assign LOADPC  = r_loadpc;
    assign PC_INC  = r_pc_inc;
    assign IR_CU   = r_ir_cu;
    assign UNDEF   = r_undef;
    assign TIMEOUT = r_timeout;
    assign RETIRED = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_dp_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_control_unit
// Brief    : Table-driven scoreboard bench for dp_control_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_control_unit;

    localparam int CNT_W         = 4;
    localparam int FETCH_TIMEOUT = 4;

    logic             Clk = 1'b0;
    logic             RESET;
    logic [31:0]      MEM_DATA;
    logic             MFC;
    logic [3:0]       FLAGS;
    logic [31:0]      IR;
    logic             MOV;
    logic [19:0]      RSLCT;
    logic [4:0]       OP;
    logic             S;
    logic             ALU_OUT;
    logic             LOAD;
    logic             LOADPC;
    logic             PC_INC;
    logic             IR_CU;
    logic             UNDEF;
    logic             TIMEOUT;
    logic [CNT_W-1:0] RETIRED;

    dp_control_unit #(
        .CNT_W        (CNT_W),
        .FETCH_TIMEOUT(FETCH_TIMEOUT)
    ) u_dut (
        .Clk     (Clk),
        .RESET   (RESET),
        .MEM_DATA(MEM_DATA),
        .MFC     (MFC),
        .FLAGS   (FLAGS),
        .IR      (IR),
        .MOV     (MOV),
        .RSLCT   (RSLCT),
        .OP      (OP),
        .S       (S),
        .ALU_OUT (ALU_OUT),
        .LOAD    (LOAD),
        .LOADPC  (LOADPC),
        .PC_INC  (PC_INC),
        .IR_CU   (IR_CU),
        .UNDEF   (UNDEF),
        .TIMEOUT (TIMEOUT),
        .RETIRED (RETIRED)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0]      ir;
        logic             mov;
        logic             chk_rslct;
        logic [19:0]      rslct;
        logic [4:0]       op;
        logic             s;
        logic             alu_out;
        logic             load;
        logic             loadpc;
        logic             pc_inc;
        logic             ir_cu;
        logic             undef;
        logic             timeout;
        logic [CNT_W-1:0] retired;
    } obs_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  flags;
        logic        exec;
        logic        undef;
        logic [4:0]  op;
        logic        s;
        logic        load;
        logic [19:0] rslct;
    } vec_t;

    obs_t             sb_q[$];
    vec_t             vecs[17];
    int               checks = 0;
    int               errors = 0;
    logic [31:0]      exp_ir;
    logic [CNT_W-1:0] exp_ret;
    logic             exp_to;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic obs_t base_obs();
        obs_t o;
        o.ir = exp_ir;         o.mov = 1'b0;     o.chk_rslct = 1'b1;
        o.rslct = 20'hF0000;   o.op = 5'd17;     o.s = 1'b0;
        o.alu_out = 1'b0;      o.load = 1'b0;    o.loadpc = 1'b0;
        o.pc_inc = 1'b0;       o.ir_cu = 1'b0;   o.undef = 1'b0;
        o.timeout = exp_to;    o.retired = exp_ret;
        return o;
    endfunction

    function automatic obs_t reset_obs();
        obs_t o;
        o = base_obs();
        o.rslct = 20'h0;
        return o;
    endfunction

    task automatic tick(input string tag);
        obs_t e;
        @(posedge Clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".IR"},      IR,      e.ir);
            chk({tag, ".MOV"},     32'(MOV),     32'(e.mov));
            if (e.chk_rslct) chk({tag, ".RSLCT"}, 32'(RSLCT), 32'(e.rslct));
            chk({tag, ".OP"},      32'(OP),      32'(e.op));
            chk({tag, ".S"},       32'(S),       32'(e.s));
            chk({tag, ".ALU_OUT"}, 32'(ALU_OUT), 32'(e.alu_out));
            chk({tag, ".LOAD"},    32'(LOAD),    32'(e.load));
            chk({tag, ".LOADPC"},  32'(LOADPC),  32'(e.loadpc));
            chk({tag, ".PC_INC"},  32'(PC_INC),  32'(e.pc_inc));
            chk({tag, ".IR_CU"},   32'(IR_CU),   32'(e.ir_cu));
            chk({tag, ".UNDEF"},   32'(UNDEF),   32'(e.undef));
            chk({tag, ".TIMEOUT"}, 32'(TIMEOUT), 32'(e.timeout));
            chk({tag, ".RETIRED"}, 32'(RETIRED), 32'(e.retired));
        end
    endtask

    task automatic do_reset(input string tag);
        RESET   = 1'b1;
        exp_ir  = '0;
        exp_ret = '0;
        exp_to  = 1'b0;
        sb_q.push_back(reset_obs());
        tick(tag);
    endtask

    // Starts with the DUT in FETCH; flags are inverted outside DECODE to prove they are ignored there.
    task automatic run_vec(input vec_t v, input bit abort);
        obs_t o;
        MEM_DATA = v.data;
        MFC      = 1'b1;
        FLAGS    = ~v.flags;
        exp_ir   = v.data;
        o = base_obs(); o.chk_rslct = 1'b0; o.loadpc = 1'b1; o.pc_inc = 1'b1;
        sb_q.push_back(o);
        tick("pc_upd");
        MEM_DATA = 32'hDEAD_BEEF ^ v.data;
        o = base_obs(); o.rslct = v.rslct; o.ir_cu = 1'b1; o.undef = v.undef;
        sb_q.push_back(o);
        tick("decode");
        FLAGS = v.flags;
        if (v.exec) begin
            exp_ret = exp_ret + 1'b1;
            o = base_obs(); o.rslct = v.rslct; o.ir_cu = 1'b1; o.op = v.op; o.s = v.s;
            o.load = v.load; o.alu_out = 1'b1;
            sb_q.push_back(o);
            tick("execute");
            FLAGS = ~v.flags;
            if (abort) begin
                do_reset("abort_in_execute");
                RESET = 1'b0;
                return;
            end
        end
        o = base_obs(); o.mov = 1'b1;
        sb_q.push_back(o);
        tick("fetch");
    endtask

    function automatic vec_t mkv(input logic [31:0] d, input logic [3:0] f, input logic ex,
                                 input logic ud, input logic [4:0] op, input logic s,
                                 input logic ld, input logic [19:0] rs);
        vec_t v;
        v.data = d; v.flags = f; v.exec = ex; v.undef = ud;
        v.op = op;  v.s = s;     v.load = ld; v.rslct = rs;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mkv(32'hE0812003, 4'b0000, 1, 0, 5'd4,  0, 1, 20'h12032); // ADD
        vecs[1]  = mkv(32'hE1510002, 4'b0000, 1, 0, 5'd10, 1, 0, 20'h10020); // CMP
        vecs[2]  = mkv(32'h00812003, 4'b0000, 0, 0, 5'd17, 0, 0, 20'h12032); // ADDEQ, Z=0
        vecs[3]  = mkv(32'h00812003, 4'b0100, 1, 0, 5'd4,  0, 1, 20'h12032); // ADDEQ, Z=1
        vecs[4]  = mkv(32'hE5912000, 4'b0000, 0, 1, 5'd17, 0, 0, 20'h12002); // LDR
        vecs[5]  = mkv(32'h10812003, 4'b0100, 0, 0, 5'd17, 0, 0, 20'h12032); // NE, Z=1
        vecs[6]  = mkv(32'h80812003, 4'b0010, 1, 0, 5'd4,  0, 1, 20'h12032); // HI
        vecs[7]  = mkv(32'h90812003, 4'b0010, 0, 0, 5'd17, 0, 0, 20'h12032); // LS fails
        vecs[8]  = mkv(32'hB0812003, 4'b1000, 1, 0, 5'd4,  0, 1, 20'h12032); // LT
        vecs[9]  = mkv(32'hC0812003, 4'b1001, 1, 0, 5'd4,  0, 1, 20'h12032); // GT
        vecs[10] = mkv(32'hD0812003, 4'b0000, 0, 0, 5'd17, 0, 0, 20'h12032); // LE fails
        vecs[11] = mkv(32'hF0812003, 4'b0100, 0, 0, 5'd17, 0, 0, 20'h12032); // never
        vecs[12] = mkv(32'hE1A03004, 4'b0000, 1, 0, 5'd13, 0, 1, 20'h03043); // MOV
        vecs[13] = mkv(32'hE1330004, 4'b0000, 1, 0, 5'd9,  1, 0, 20'h30040); // TEQ
        vecs[14] = mkv(32'hEA000000, 4'b0000, 0, 1, 5'd17, 0, 0, 20'h00000); // B
        vecs[15] = mkv(32'h05912000, 4'b0000, 0, 1, 5'd17, 0, 0, 20'h12002); // LDREQ, undef first
        vecs[16] = mkv(32'hE1912003, 4'b0000, 1, 0, 5'd12, 1, 1, 20'h12032); // ORRS

        MFC      = 1'b1;
        MEM_DATA = 32'hE0812003;
        FLAGS    = 4'b0000;
        do_reset("reset0");
        do_reset("reset1");
        RESET = 1'b0;

        // Two passes push RETIRED (4 bits) past all-ones
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 17; i++) begin
                run_vec(vecs[i], 1'b0);
            end
        end

        // Fetch timeout: MOV retried, TIMEOUT sticky until reset
        do_reset("reset_to");
        RESET = 1'b0;
        MFC   = 1'b0;
        for (int k = 1; k <= FETCH_TIMEOUT + 2; k++) begin
            obs_t o;
            exp_to = (k >= FETCH_TIMEOUT);
            o = base_obs();
            o.mov = 1'b1;
            sb_q.push_back(o);
            tick("timeout_wait");
        end
        run_vec(vecs[1], 1'b0);
        run_vec(vecs[0], 1'b0);
        do_reset("timeout_clear");
        RESET = 1'b0;

        // Reset during EXECUTE, then a clean instruction afterwards
        run_vec(vecs[0], 1'b1);
        run_vec(vecs[12], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
